// File: rtl/ticket_fare_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ticket_fare_ctrl
// Purpose  : Fare/payment controller for the ticket vending machine. It
//            accumulates coins against a selected ticket price, issues the
//            ticket or refunds on cancel, then sends the change/refund amount
//            to the Display stage using a ready-then-data handshake. It waits
//            for Display completion before the next transaction starts.
// Option   : DISP_TIMEOUT_EN - enables a Display-done timeout in WAIT_DISP
//            that sets a sticky err flag and returns to COLLECT.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-low reset
//            coin_valid   - one-cycle coin strobe, coin_val sampled with it
//            coin_val     - coin value [DATA_W]
//            sel_valid    - one-cycle selection strobe, sel sampled with it
//            sel          - ticket type 0..3
//            cancel       - one-cycle abort/refund strobe
//            disp_done    - Display finished (level)
//            out_RDY1     - ready pulse to Display
//            DATA_out1    - change/refund amount to Display [DATA_W]
//            ticket_issue - one-cycle dispense pulse
//            refund       - one-cycle refund pulse
//            coin_rej     - one-cycle coin-rejected pulse
//            busy         - high in any state other than COLLECT
//            err          - sticky Display-timeout flag (0 without option)
// Revision : 1.0 - initial release
// ============================================================================
module ticket_fare_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PRICE0      = 5,
  parameter int unsigned PRICE1      = 10,
  parameter int unsigned PRICE2      = 15,
  parameter int unsigned PRICE3      = 20,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [DATA_W-1:0] coin_val,
  input  logic              sel_valid,
  input  logic [1:0]        sel,
  input  logic              cancel,
  input  logic              disp_done,
  output logic              out_RDY1,
  output logic [DATA_W-1:0] DATA_out1,
  output logic              ticket_issue,
  output logic              refund,
  output logic              coin_rej,
  output logic              busy,
  output logic              err
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_COLLECT   = 3'd0,
    S_ISSUE     = 3'd1,
    S_REFUND    = 3'd2,
    S_SEND_RDY  = 3'd3,
    S_SEND_DATA = 3'd4,
    S_WAIT_DISP = 3'd5
  } state_t;

  state_t            r_state, w_state_nx;
  logic [DATA_W-1:0] r_credit, w_credit_nx;
  logic [DATA_W-1:0] r_price, w_price_nx;
  logic              r_sel_ok, w_sel_ok_nx;
  logic [DATA_W-1:0] r_xfer, w_xfer_nx;
  logic              r_wait_arm, w_wait_arm_nx;  // set after first WAIT_DISP cycle
  logic              r_coin_rej, w_coin_rej_nx;
  logic [DATA_W:0]   w_sum;                      // extra bit flags overflow
  logic [DATA_W-1:0] w_sel_price;

`ifdef DISP_TIMEOUT_EN
  localparam int unsigned c_tmo_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [c_tmo_w-1:0] r_tmo_cnt, w_tmo_cnt_nx;
  logic               r_err, w_err_nx;
`endif

  assign w_sum = {1'b0, r_credit} + {1'b0, coin_val};

  always_comb begin
    w_sel_price = DATA_W'(PRICE0);
    case (sel)
      2'd0:    w_sel_price = DATA_W'(PRICE0);
      2'd1:    w_sel_price = DATA_W'(PRICE1);
      2'd2:    w_sel_price = DATA_W'(PRICE2);
      default: w_sel_price = DATA_W'(PRICE3);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_COLLECT;
      r_credit   <= '0;
      r_price    <= '0;
      r_sel_ok   <= 1'b0;
      r_xfer     <= '0;
      r_wait_arm <= 1'b0;
      r_coin_rej <= 1'b0;
`ifdef DISP_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_credit   <= w_credit_nx;
      r_price    <= w_price_nx;
      r_sel_ok   <= w_sel_ok_nx;
      r_xfer     <= w_xfer_nx;
      r_wait_arm <= w_wait_arm_nx;
      r_coin_rej <= w_coin_rej_nx;
`ifdef DISP_TIMEOUT_EN
      r_tmo_cnt  <= w_tmo_cnt_nx;
      r_err      <= w_err_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_credit_nx   = r_credit;
    w_price_nx    = r_price;
    w_sel_ok_nx   = r_sel_ok;
    w_xfer_nx     = r_xfer;
    w_wait_arm_nx = r_wait_arm;
    // Any coin arriving outside COLLECT is bounced; COLLECT overrides below.
    w_coin_rej_nx = coin_valid && (r_state != S_COLLECT);
    out_RDY1      = 1'b0;
    DATA_out1     = '0;
    ticket_issue  = 1'b0;
    refund        = 1'b0;
`ifdef DISP_TIMEOUT_EN
    w_tmo_cnt_nx  = r_tmo_cnt;
    w_err_nx      = r_err;
`endif

    case (r_state)
      S_COLLECT: begin
        // Cancel with nothing inserted has nothing to refund, so it is ignored.
        if (cancel && (r_credit != '0)) begin
          w_state_nx    = S_REFUND;
          w_coin_rej_nx = coin_valid;
        end else begin
          if (coin_valid) begin
            if (w_sum[DATA_W]) begin
              w_coin_rej_nx = 1'b1;
            end else begin
              w_credit_nx = w_sum[DATA_W-1:0];
            end
          end
          if (sel_valid) begin
            w_price_nx  = w_sel_price;
            w_sel_ok_nx = 1'b1;
          end
          if (w_sel_ok_nx && (w_credit_nx >= w_price_nx)) begin
            w_state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        ticket_issue = 1'b1;
        w_xfer_nx    = r_credit - r_price;
        w_state_nx   = S_SEND_RDY;
      end
      S_REFUND: begin
        refund     = 1'b1;
        w_xfer_nx  = r_credit;
        w_state_nx = S_SEND_RDY;
      end
      S_SEND_RDY: begin
        out_RDY1   = 1'b1;
        w_state_nx = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        DATA_out1     = r_xfer;
        w_state_nx    = S_WAIT_DISP;
        w_credit_nx   = '0;
        w_price_nx    = '0;
        w_sel_ok_nx   = 1'b0;
        w_wait_arm_nx = 1'b0;
`ifdef DISP_TIMEOUT_EN
        w_tmo_cnt_nx  = '0;
`endif
      end
      S_WAIT_DISP: begin
        // The first cycle ignores disp_done so a level left over from the
        // previous transaction cannot end this wait.
        w_wait_arm_nx = 1'b1;
`ifdef DISP_TIMEOUT_EN
        if (r_wait_arm && disp_done) begin
          w_state_nx = S_COLLECT;
        end else if (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1)) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_COLLECT;
        end else begin
          w_tmo_cnt_nx = r_tmo_cnt + 1'b1;
        end
`else
        if (r_wait_arm && disp_done) begin
          w_state_nx = S_COLLECT;
        end
`endif
      end
      default: begin
        w_state_nx = S_COLLECT;
      end
    endcase
  end

  assign coin_rej = r_coin_rej;
  assign busy     = (r_state != S_COLLECT);

`ifdef DISP_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ticket_fare_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ticket_fare_ctrl
// Purpose  : Directed self-checking bench for ticket_fare_ctrl. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ticket_fare_ctrl;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              coin_valid;
  logic [DATA_W-1:0] coin_val;
  logic              sel_valid;
  logic [1:0]        sel;
  logic              cancel;
  logic              disp_done;
  logic              out_RDY1;
  logic [DATA_W-1:0] DATA_out1;
  logic              ticket_issue;
  logic              refund;
  logic              coin_rej;
  logic              busy;
  logic              err;

  int total = 0;
  int bad   = 0;

  ticket_fare_ctrl #(
    .DATA_W      (DATA_W),
    .PRICE0      (5),
    .PRICE1      (10),
    .PRICE2      (15),
    .PRICE3      (20),
    .TIMEOUT_CYC (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .disp_done    (disp_done),
    .out_RDY1     (out_RDY1),
    .DATA_out1    (DATA_out1),
    .ticket_issue (ticket_issue),
    .refund       (refund),
    .coin_rej     (coin_rej),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every handshake/pulse output at once.
  task automatic chk_out(input string tag, input logic e_iss, input logic e_ref,
                         input logic e_rdy, input logic [7:0] e_data,
                         input logic e_rej, input logic e_busy);
    chk({tag, ".ticket_issue"}, ticket_issue, e_iss);
    chk({tag, ".refund"},       refund,       e_ref);
    chk({tag, ".out_RDY1"},     out_RDY1,     e_rdy);
    chk({tag, ".DATA_out1"},    DATA_out1,    e_data);
    chk({tag, ".coin_rej"},     coin_rej,     e_rej);
    chk({tag, ".busy"},         busy,         e_busy);
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1; coin_val = v;
    tick();
    coin_valid = 1'b0; coin_val = '0;
  endtask

  task automatic select(input logic [1:0] s);
    sel_valid = 1'b1; sel = s;
    tick();
    sel_valid = 1'b0; sel = '0;
  endtask

  // Called while observing the first WAIT_DISP cycle: raise done there (it
  // must be ignored), then expect the exit one cycle later.
  task automatic finish_disp(input string tag);
    disp_done = 1'b1;
    tick();
    chk({tag, ".wait2_busy"}, busy, 1'b1);
    tick();
    chk({tag, ".idle_busy"}, busy, 1'b0);
    disp_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0; coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0;
    sel = '0; cancel = 1'b0; disp_done = 1'b0;

    // ---- 1: reset, then sel=1 with coins 5,5 -> change 0 ----
    tick(); tick();
    chk_out("rst", 0, 0, 0, 8'h00, 0, 0);
    chk("rst.err", err, 1'b0);
    rst = 1'b1;
    select(2'd1);
    chk("t1.sel_busy", busy, 1'b0);
    coin(8'd5);
    chk_out("t1.c1", 0, 0, 0, 8'h00, 0, 0);
    coin(8'd5);
    chk_out("t1.issue", 1, 0, 0, 8'h00, 0, 1);
    tick();
    chk_out("t1.rdy", 0, 0, 1, 8'h00, 0, 1);
    tick();
    chk_out("t1.data", 0, 0, 0, 8'h00, 0, 1);
    tick();
    chk_out("t1.wait", 0, 0, 0, 8'h00, 0, 1);
    finish_disp("t1");

    // ---- 2: sel=0 and coin 10 together -> change 5 ----
    sel_valid = 1'b1; sel = 2'd0; coin_valid = 1'b1; coin_val = 8'd10;
    tick();
    sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
    chk_out("t2.issue", 1, 0, 0, 8'h00, 0, 1);
    tick();
    chk_out("t2.rdy", 0, 0, 1, 8'h00, 0, 1);
    tick();
    chk_out("t2.data", 0, 0, 0, 8'h05, 0, 1);
    tick();
    chk_out("t2.wait", 0, 0, 0, 8'h00, 0, 1);
    finish_disp("t2");

    // ---- 3: coins 3,4 then cancel -> refund 7 ----
    coin(8'd3);
    coin(8'd4);
    chk("t3.no_issue", busy, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_out("t3.refund", 0, 1, 0, 8'h00, 0, 1);
    tick();
    chk_out("t3.rdy", 0, 0, 1, 8'h00, 0, 1);
    tick();
    chk_out("t3.data", 0, 0, 0, 8'h07, 0, 1);
    tick();
    chk_out("t3.wait", 0, 0, 0, 8'h00, 0, 1);
    finish_disp("t3");
    // Credit is now 0, so cancel must be ignored.
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_out("t3.cancel0", 0, 0, 0, 8'h00, 0, 0);

    // ---- 4: coin 200, coin 100 rejected, sel=3 -> change 180 ----
    coin(8'd200);
    chk_out("t4.c200", 0, 0, 0, 8'h00, 0, 0);
    coin(8'd100);
    chk_out("t4.c100", 0, 0, 0, 8'h00, 1, 0);
    select(2'd3);
    chk_out("t4.issue", 1, 0, 0, 8'h00, 0, 1);
    tick();
    chk_out("t4.rdy", 0, 0, 1, 8'h00, 0, 1);
    tick();
    chk_out("t4.data", 0, 0, 0, 8'hB4, 0, 1);
    tick();
    chk_out("t4.wait", 0, 0, 0, 8'h00, 0, 1);
    finish_disp("t4");

    // ---- 5: coin in WAIT_DISP, reset mid-wait, cancel+coin with credit 6 ----
    select(2'd0);
    coin(8'd5);
    chk("t5.issue", ticket_issue, 1'b1);
    tick(); tick(); tick();
    chk_out("t5.wait", 0, 0, 0, 8'h00, 0, 1);
    coin(8'd7);
    chk_out("t5.wait_rej", 0, 0, 0, 8'h00, 1, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_out("t5.rst", 0, 0, 0, 8'h00, 0, 0);
    coin(8'd6);
    chk_out("t5.c6", 0, 0, 0, 8'h00, 0, 0);
    cancel = 1'b1; coin_valid = 1'b1; coin_val = 8'd3;
    tick();
    cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
    chk_out("t5.refund", 0, 1, 0, 8'h00, 1, 1);
    tick();
    chk_out("t5.rdy", 0, 0, 1, 8'h00, 0, 1);
    tick();
    chk_out("t5.data", 0, 0, 0, 8'h06, 0, 1);
    tick();
    chk_out("t5.wait2", 0, 0, 0, 8'h00, 0, 1);
    finish_disp("t5");

    // ---- 6: disp_done never arrives ----
    select(2'd0);
    coin(8'd5);
    tick(); tick(); tick();
    chk("t6.wait1_busy", busy, 1'b1);
`ifdef DISP_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("t6.wait8_busy", busy, 1'b1);
    chk("t6.wait8_err", err, 1'b0);
    tick();
    chk("t6.tmo_busy", busy, 1'b0);
    chk("t6.tmo_err", err, 1'b1);
`else
    for (int i = 0; i < 12; i++) tick();
    chk("t6.hold_busy", busy, 1'b1);
    chk("t6.hold_err", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
